// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among NUM_MASTERS requesters with
// parking on DEFAULT_MASTER, locked-transfer support and a hold limit
// that forces rearbitration of long-running owners.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_MASTERS-1:0]         busreq,
  input  logic [NUM_MASTERS-1:0]         lock,
  input  logic [1:0]                     trans,
  input  logic                           ready,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] addr_master,
  output logic [$clog2(NUM_MASTERS)-1:0] data_master,
  output logic                           mastlock
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;

  typedef enum logic [1:0] {
    PARK,
    OWN,
    LOCK
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] owner, owner_next;
  logic [IW-1:0] data_owner;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          arb;
  logic          found;
  logic [IW-1:0] cand_owner;

  // Round-robin search starting just after the current owner; the owner
  // itself is the last candidate so it only keeps the bus if nobody else asks.
  always_comb begin
    found      = 1'b0;
    cand_owner = owner;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!found && busreq[(int'(owner) + i) % NUM_MASTERS]) begin
        found      = 1'b1;
        cand_owner = IW'((int'(owner) + i) % NUM_MASTERS);
      end
    end
  end

  // Next-state logic: detect arbitration points, lock entry/exit and
  // maintain the hold counter; nothing moves while ready is low.
  always_comb begin
    state_next = state;
    owner_next = owner;
    hold_next  = hold_cnt;
    arb        = 1'b0;
    if (ready) begin
      if (state == OWN && hold_cnt < HW'(MAX_HOLD))
        hold_next = hold_cnt + HW'(1);
      if (state == LOCK) begin
        if (!lock[owner] && trans == TRANS_IDLE)
          arb = 1'b1;
      end else if (lock[owner] && trans == TRANS_NONSEQ) begin
        state_next = LOCK;
      end else if (trans == TRANS_IDLE || !busreq[owner] ||
                   (hold_cnt >= HW'(MAX_HOLD) && trans == TRANS_NONSEQ)) begin
        arb = 1'b1;
      end else if (state == PARK) begin
        state_next = OWN;
      end
      if (arb) begin
        if (found) begin
          owner_next = cand_owner;
          state_next = OWN;
        end else begin
          owner_next = IW'(DEFAULT_MASTER);
          state_next = PARK;
        end
      end
      if (owner_next != owner || state_next == PARK)
        hold_next = '0;
    end
  end

  // State registers; reset parks the bus on the default master at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= PARK;
      owner      <= IW'(DEFAULT_MASTER);
      data_owner <= IW'(DEFAULT_MASTER);
      hold_cnt   <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      hold_cnt <= hold_next;
      if (ready)
        data_owner <= owner;
    end
  end

  assign grant       = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner;
  assign addr_master = owner;
  assign data_master = data_owner;
  assign mastlock    = (state == LOCK);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter: a vector table for the basic
// arbitration sequence plus hand-written multi-cycle corner cases.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic       clk;
  logic       rstn;
  logic [3:0] busreq;
  logic [3:0] lock;
  logic [1:0] trans;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] addr_master;
  logic [1:0] data_master;
  logic       mastlock;

  int n_applied;
  int n_miss;

  typedef struct {
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic [3:0] exp_grant;
    logic [1:0] exp_addr;
    logic [1:0] exp_data;
    logic       exp_ml;
  } vec_t;

  vec_t vecs[14];

  ahb_arbiter #(
    .NUM_MASTERS(4),
    .MAX_HOLD(16),
    .DEFAULT_MASTER(0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .busreq(busreq),
    .lock(lock),
    .trans(trans),
    .ready(ready),
    .grant(grant),
    .addr_master(addr_master),
    .data_master(data_master),
    .mastlock(mastlock)
  );

  // Free-running bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [3:0] b, input logic [3:0] l,
                                input logic [1:0] t, input logic r);
    busreq = b;
    lock   = l;
    trans  = t;
    ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] got,
                              input logic [15:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] eg,
                           input logic [1:0] ea, input logic [1:0] ed,
                           input logic eml);
    check_output({name, " grant"}, 16'(grant), 16'(eg));
    check_output({name, " addr_master"}, 16'(addr_master), 16'(ea));
    check_output({name, " data_master"}, 16'(data_master), 16'(ed));
    check_output({name, " mastlock"}, 16'(mastlock), 16'(eml));
  endtask

  // Main test sequence.
  initial begin
    n_applied = 0;
    n_miss    = 0;

    vecs[0]  = '{4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b0};
    vecs[2]  = '{4'b1010, 4'b0000, T_IDLE,   1'b1, 4'b0010, 2'd1, 2'd0, 1'b0};
    vecs[3]  = '{4'b1010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
    vecs[4]  = '{4'b1000, 4'b0000, T_IDLE,   1'b1, 4'b1000, 2'd3, 2'd1, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0000, T_SEQ,    1'b0, 4'b1000, 2'd3, 2'd1, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 2'd3, 1'b0};
    vecs[7]  = '{4'b0110, 4'b0000, T_IDLE,   1'b0, 4'b0001, 2'd0, 2'd3, 1'b0};
    vecs[8]  = '{4'b0110, 4'b0000, T_IDLE,   1'b1, 4'b0010, 2'd1, 2'd0, 1'b0};
    vecs[9]  = '{4'b0110, 4'b0000, T_BUSY,   1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
    vecs[10] = '{4'b0100, 4'b0000, T_SEQ,    1'b1, 4'b0100, 2'd2, 2'd1, 1'b0};
    vecs[11] = '{4'b0101, 4'b0000, T_NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0};
    vecs[12] = '{4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd0, 2'd2, 1'b0};
    vecs[13] = '{4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0100, 2'd2, 2'd0, 1'b0};

    rstn   = 1'b0;
    busreq = '0;
    lock   = '0;
    trans  = T_IDLE;
    ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven basic arbitration sequence.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].busreq, vecs[i].lock, vecs[i].trans, vecs[i].ready);
      check_all($sformatf("v%0d", i), vecs[i].exp_grant, vecs[i].exp_addr,
                vecs[i].exp_data, vecs[i].exp_ml);
    end

    // Hold limit: master 3 keeps bursting, master 0 waiting.
    apply_stimulus(4'b1000, 4'b0000, T_IDLE, 1'b1);
    check_output("hold start grant", 16'(grant), 16'(4'b1000));
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(4'b1001, 4'b0000, (i % 4 == 0) ? T_NONSEQ : T_SEQ, 1'b1);
      check_output($sformatf("hold c%0d grant", i), 16'(grant), 16'(4'b1000));
    end
    apply_stimulus(4'b1001, 4'b0000, T_SEQ, 1'b1);
    check_output("hold seq grant", 16'(grant), 16'(4'b1000));
    apply_stimulus(4'b1001, 4'b0000, T_NONSEQ, 1'b1);
    check_all("hold expire", 4'b0001, 2'd0, 2'd3, 1'b0);

    // Locked transfer by master 2 with everyone requesting.
    apply_stimulus(4'b0100, 4'b0000, T_IDLE, 1'b1);
    check_output("lock own grant", 16'(grant), 16'(4'b0100));
    apply_stimulus(4'b1111, 4'b0100, T_NONSEQ, 1'b1);
    check_all("lock enter", 4'b0100, 2'd2, 2'd2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: apply_stimulus(4'b1111, 4'b0100, T_SEQ, 1'b1);
        1: apply_stimulus(4'b1111, 4'b0100, T_IDLE, 1'b1);
        2: apply_stimulus(4'b1111, 4'b0100, T_BUSY, 1'b1);
        default: apply_stimulus(4'b1111, 4'b0100, T_NONSEQ, 1'b1);
      endcase
      check_output($sformatf("lock c%0d grant", i), 16'(grant), 16'(4'b0100));
      check_output($sformatf("lock c%0d mastlock", i), 16'(mastlock), 16'(1'b1));
    end
    apply_stimulus(4'b1111, 4'b0000, T_IDLE, 1'b1);
    check_all("lock exit", 4'b1000, 2'd3, 2'd2, 1'b0);

    // Arbitration point held off by ready low.
    apply_stimulus(4'b1000, 4'b0000, T_NONSEQ, 1'b1);
    check_all("freeze pre", 4'b1000, 2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(4'b0001, 4'b0000, T_IDLE, 1'b0);
      check_all($sformatf("freeze w%0d", i), 4'b1000, 2'd3, 2'd3, 1'b0);
    end
    apply_stimulus(4'b0001, 4'b0000, T_IDLE, 1'b1);
    check_all("freeze switch", 4'b0001, 2'd0, 2'd3, 1'b0);
    apply_stimulus(4'b0001, 4'b0000, T_NONSEQ, 1'b1);
    check_all("freeze follow", 4'b0001, 2'd0, 2'd0, 1'b0);

    // Asynchronous reset while locked.
    apply_stimulus(4'b0100, 4'b0000, T_IDLE, 1'b1);
    check_all("rst own", 4'b0100, 2'd2, 2'd0, 1'b0);
    apply_stimulus(4'b0100, 4'b0100, T_NONSEQ, 1'b1);
    check_all("rst lock", 4'b0100, 2'd2, 2'd2, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all("rst async", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst held", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    apply_stimulus(4'b0100, 4'b0100, T_IDLE, 1'b1);
    check_all("rst first arb", 4'b0100, 2'd2, 2'd0, 1'b0);
    apply_stimulus(4'b0100, 4'b0100, T_NONSEQ, 1'b1);
    check_all("rst relock", 4'b0100, 2'd2, 2'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
